// File: rtl/loop_pipe_pkg.sv
// Shared defaults and helpers for the loop_pipe STA regression design.
// Counters narrower than or equal to 32 bits share a single saturating increment.
package loop_pipe_pkg;

    localparam int DEF_WIDTH = 4;
    localparam int DEF_DEPTH = 2;
    localparam int DEF_CNT_W = 8;
    localparam int MAX_CNT_W = 32;

    // Increment v unless it already holds the all-ones value of a w-bit counter.
    function automatic logic [MAX_CNT_W-1:0] sat_inc(input logic [MAX_CNT_W-1:0] v,
                                                     input int unsigned           w);
        logic [MAX_CNT_W-1:0] max_v;
        if (w >= MAX_CNT_W) max_v = '1;
        else                max_v = (MAX_CNT_W'(1) << w) - MAX_CNT_W'(1);
        return (v >= max_v) ? v : v + MAX_CNT_W'(1);
    endfunction

endpackage

// File: rtl/loop_lane.sv
// One lane: capture register (f1/n1), registered NOR feedback loop and
// saturating toggle counter. Valid/ready does not apply: capture is strobe-only.
module loop_lane
    import loop_pipe_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             cap_i,
    input  logic             a_i,
    input  logic             b_i,
    input  logic             clr_i,
    output logic             n1_o,
    output logic             lp_o,
    output logic [CNT_W-1:0] cnt_o
);

    logic             f1_q, f1_d;
    logic             n1_q, n1_d;
    logic             lp_q, lp_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        f1_d  = f1_q;
        n1_d  = n1_q;
        if (cap_i) begin
            f1_d = a_i;
            n1_d = ~(a_i & b_i);
        end
        // The NOR loop is closed through lp_q, so f1=1 parks the lane at 0.
        lp_d  = ~(f1_q | lp_q);
        cnt_d = cnt_q;
        if (clr_i)
            cnt_d = '0;
        else if (lp_d != lp_q)
            cnt_d = CNT_W'(sat_inc(MAX_CNT_W'(cnt_q), CNT_W));
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            f1_q  <= 1'b0;
            n1_q  <= 1'b0;
            lp_q  <= 1'b0;
            cnt_q <= '0;
        end else begin
            f1_q  <= f1_d;
            n1_q  <= n1_d;
            lp_q  <= lp_d;
            cnt_q <= cnt_d;
        end
    end

    assign n1_o  = n1_q;
    assign lp_o  = lp_q;
    assign cnt_o = cnt_q;

endmodule

// File: rtl/loop_pipe.sv
// WIDTH-lane NAND/NOR-loop design with a DEPTH-stage output pipeline.
// No back-pressure: every chain shifts on each rising edge.
module loop_pipe
    import loop_pipe_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic                   tau2015_clk,
    input  logic                   rst,
    input  logic                   in_valid,
    input  logic [WIDTH-1:0]       inp1,
    input  logic [WIDTH-1:0]       inp2,
    input  logic                   clr_cnt,
    output logic                   out_valid,
    output logic [WIDTH-1:0]       nand_out,
    output logic [WIDTH-1:0]       out,
    output logic [WIDTH*CNT_W-1:0] toggle_cnt
);

    logic             v_q;
    logic [WIDTH-1:0] n1_w;
    logic [WIDTH-1:0] lp_w;

    logic [DEPTH-1:0] v_pipe_q;
    logic [WIDTH-1:0] n1_pipe_q [DEPTH];
    logic [WIDTH-1:0] lp_pipe_q [DEPTH];

    for (genvar i = 0; i < WIDTH; i++) begin : g_lane
        loop_lane #(.CNT_W(CNT_W)) u_lane (
            .clk_i (tau2015_clk),
            .rst_i (rst),
            .cap_i (in_valid),
            .a_i   (inp1[i]),
            .b_i   (inp2[i]),
            .clr_i (clr_cnt),
            .n1_o  (n1_w[i]),
            .lp_o  (lp_w[i]),
            .cnt_o (toggle_cnt[i*CNT_W +: CNT_W])
        );
    end

    // Stage 0 is fed from the capture/loop registers; the last stage drives the outputs.
    always_ff @(posedge tau2015_clk) begin
        if (rst) begin
            v_q      <= 1'b0;
            v_pipe_q <= '0;
            for (int s = 0; s < DEPTH; s++) begin
                n1_pipe_q[s] <= '0;
                lp_pipe_q[s] <= '0;
            end
        end else begin
            v_q          <= in_valid;
            v_pipe_q[0]  <= v_q;
            n1_pipe_q[0] <= n1_w;
            lp_pipe_q[0] <= lp_w;
            for (int s = 1; s < DEPTH; s++) begin
                v_pipe_q[s]  <= v_pipe_q[s-1];
                n1_pipe_q[s] <= n1_pipe_q[s-1];
                lp_pipe_q[s] <= lp_pipe_q[s-1];
            end
        end
    end

    assign out_valid = v_pipe_q[DEPTH-1];
    assign nand_out  = n1_pipe_q[DEPTH-1];
    assign out       = lp_pipe_q[DEPTH-1];

endmodule

// File: doc/loop_pipe.md
# loop_pipe

- Parametrised, register-broken successor to the single-lane NAND/flop/NOR/INV loop example in the iSTA example-design set.
- Carries WIDTH independent lanes. Each lane has:
  - an input capture register;
  - a NAND data path;
  - a NOR feedback loop closed through a register instead of combinationally;
  - a saturating toggle counter.
- Results leave through a DEPTH-stage output pipeline.
- Serves as an STA regression design with real sequential depth, multi-stage paths and a register-to-register feedback path.

## Interface
Parameters:
- WIDTH, 4, number of lanes (≥1)
- DEPTH, 2, output pipeline stages (≥1)
- CNT_W, 8, toggle counter width per lane (≥2)

Ports:
- Clock and reset: one clock, `tau2015_clk`; reset `rst` is synchronous and active-high.
- tau2015_clk  in  1  sole clock, all state updates on rising edge
- rst  in  1  synchronous active-high reset
- in_valid  in  1  capture strobe for inp1/inp2
- inp1  in  WIDTH  lane data A
- inp2  in  WIDTH  lane data B
- clr_cnt  in  1  synchronous clear of all toggle counters
- out_valid  out  1  nand_out slot holds a valid capture
- nand_out  out  WIDTH  ~(inp1 & inp2) of captured slot, delayed
- out  out  WIDTH  loop register value, delayed DEPTH cycles, free-running
- toggle_cnt  out  WIDTH*CNT_W  lane i counter at bits [i*CNT_W +: CNT_W]

## Operation
- Capture, per lane i, when in_valid=1:
  - f1_q[i] ← inp1[i]
  - n1_q[i] ← ~(inp1[i] & inp2[i])
  - When in_valid=0, f1_q and n1_q hold.
- Capture valid: v_q ← in_valid every cycle.
- Loop register, every cycle: lp_q[i] ← ~(f1_q[i] | lp_q[i]).
  - f1_q[i]=0: lp_q toggles each cycle.
  - f1_q[i]=1: lp_q is forced to 0 on the next edge and stays 0.
- Counter update, per lane:
  - clr_cnt=1 → cnt[i] ← 0. Clear has priority over increment.
  - Otherwise, if next lp_q[i] ≠ current lp_q[i] and cnt[i] < 2^CNT_W−1 → cnt[i] ← cnt[i]+1.
  - At all-ones the counter holds (saturates, no wrap).
- Output pipeline:
  - Three DEPTH-stage shift chains advance every cycle, unconditionally:
    - {v_q, n1_q} chain → {out_valid, nand_out};
    - lp_q chain → out.
  - No back-pressure.
  - When out_valid=0, nand_out carries the last held capture value and must be ignored.
- Reset (rst=1), on the next edge:
  - All of the following go to 0: f1_q, n1_q, v_q, lp_q, every pipeline stage and all counters.
  - Reset overrides in_valid and clr_cnt.
  - Reset mid-operation flushes the pipeline; no stale valid slot survives.
- Reset values of outputs: out_valid=0, nand_out=0, out=0, toggle_cnt=0.
- After reset release:
  - f1_q=0 and lp_q=0, so every lane starts toggling on the first edge with rst=0.
  - The counters count from that edge.

## Timing
- Capture latency: inputs sampled at edge k appear on nand_out/out_valid after edge k+DEPTH.
  - The capture register is stage 0, so the total is DEPTH+1 register levels.
- Loop latency: out after edge e equals lp_q after edge e−DEPTH.
- Effect of a capture: a new f1_q captured at edge k first affects lp_q at edge k+1 and out at edge k+1+DEPTH.
- Counter timing: toggle_cnt updates on the same edge as the lp_q transition it counts.
- Back-to-back in_valid: full throughput, one slot per cycle.
- Simultaneous in_valid and clr_cnt: both take effect; they are independent.
- No combinational path from any input to any output.

## Structure
- Package `loop_pipe_pkg`:
  - default values for WIDTH, DEPTH and CNT_W;
  - a `sat_inc` function for the saturating increment.
- Sub-module `loop_lane`, generated WIDTH times. It holds one lane's:
  - capture register, f1 and n1;
  - lp_q loop register;
  - toggle counter.
- The top level holds:
  - the shared v_q register;
  - the DEPTH-stage shift chains;
  - the toggle_cnt packing.

## Test plan
All scenarios use WIDTH=4, DEPTH=2, CNT_W=8.
- Reset: hold rst=1 for 2 cycles with random inputs → out_valid=0, nand_out=0, out=0, toggle_cnt=0 throughout and one cycle after.
- Free toggle: release rst with in_valid=0 →
  - lp_q alternates 4'hF, 4'h0 from the first edge;
  - out shows the same pattern 2 edges later;
  - every lane counter = 10 after 10 edges.
- NAND path: in_valid=1 at edge k with inp1=4'b1100, inp2=4'b1010, then in_valid=0 →
  - after edge k+2: nand_out=4'b0111, out_valid=1;
  - after edge k+3: out_valid=0.
- Loop kill: in_valid=1 with inp1=4'b0101 →
  - lanes 0 and 2 go to lp_q=0 within one edge and their counters freeze;
  - lanes 1 and 3 keep toggling.
- Saturation/clear: toggle all lanes for 300 cycles →
  - every counter is 8'hFF and holds;
  - clr_cnt=1 during toggling → counters 0 on the next edge, then 1 on the following edge.
- Reset mid-stream: in_valid=1 every cycle with toggling lanes, assert rst for one cycle →
  - the next edge clears everything;
  - out_valid stays 0 for 2 edges after release, even with in_valid held high.
